// File: rtl/led_scan_ctrl.sv
// Row-scan controller for the 8x8 bicolour LED matrix with double-buffered frame banks.
// Ports: CLK/RST_N clock and async active-low reset; wr_en/wr_row/wr_red/wr_green write the back bank;
//        swap_req/swap_ack exchange banks at a frame boundary; frame_start marks row 0 BLANK; led[0:27] drives the matrix.
module led_scan_ctrl #(
  parameter int DIV_COUNT    = 25000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        wr_en,
  input  logic [2:0]  wr_row,
  input  logic [7:0]  wr_red,
  input  logic [7:0]  wr_green,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        frame_start,
  output logic [0:27] led
);

  localparam int CNT_MAX = (DIV_COUNT > BLANK_CYCLES) ? DIV_COUNT : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV_COUNT - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t           state, state_nxt;
  logic [2:0]       row, row_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Two banks; front_sel picks the one being scanned, the other is the back bank.
  logic [7:0] red_bank   [0:1][0:7];
  logic [7:0] green_bank [0:1][0:7];
  logic       front_sel;
  logic       swap_pending;
  // Set by reset so the first frame after release also gets a frame_start pulse.
  logic       first_frame;

  logic        boundary;
  logic        do_swap;
  logic [0:27] led_nxt;
  logic        frame_start_nxt;
  logic        swap_ack_nxt;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= BLANK;
      row   <= 3'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    cnt_nxt   = cnt + CNT_W'(1);
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_nxt   = '0;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_nxt   = '0;
          state_nxt = BLANK;
          row_nxt   = row + 3'd1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = BLANK;
      end
    endcase
  end

  // The last SHOW cycle of row 7 is the only place banks may exchange.
  assign boundary = (state == SHOW) && (row == 3'd7) && (cnt == SHOW_LAST);
  assign do_swap  = boundary && (swap_pending || swap_req);

  // Output logic: computed from the next state so the registered outputs line up with it.
  always_comb begin
    led_nxt        = {24'hFF_FFFF, row_nxt, 1'b1};
    if (state_nxt == SHOW) begin
      // Bit k of a bitmap lands on led[7-k] / led[15-k], i.e. MSB-first on the [0:N] bus.
      led_nxt[0:7]  = ~red_bank[front_sel][row_nxt];
      led_nxt[8:15] = ~green_bank[front_sel][row_nxt];
    end
    frame_start_nxt = first_frame || boundary;
    swap_ack_nxt    = do_swap;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led         <= {24'hFF_FFFF, 3'd0, 1'b1};
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
      first_frame <= 1'b1;
    end else begin
      led         <= led_nxt;
      frame_start <= frame_start_nxt;
      swap_ack    <= swap_ack_nxt;
      first_frame <= 1'b0;
    end
  end

  // Swap bookkeeping: requests coalesce until the next boundary consumes them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      if (do_swap) begin
        front_sel <= ~front_sel;
      end
      if (boundary) begin
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Writes use this cycle's back bank, so a boundary-cycle write lands in the bank about to go live.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          red_bank[b][r]   <= 8'h00;
          green_bank[b][r] <= 8'h00;
        end
      end
    end else if (wr_en) begin
      red_bank[~front_sel][wr_row]   <= wr_red;
      green_bank[~front_sel][wr_row] <= wr_green;
    end
  end

endmodule
